e203_dsp_cpa_seq: RTL and testbench
===================================

# e203_dsp_cpa_seq

Sequential carry-propagate adder that resolves the carry-save pair produced by the DSP 4:2 compressor tree into a single binary result. It sits directly downstream of the compressor stage in the DSP multiply path. It adds the redundant carry/sum vectors in CW-bit chunks over several cycles, so the long carry chain does not set the cycle time. A valid/ready handshake sits on each side, and a flush input kills an in-flight operation.

## Interface
- DW, 106, operand/result width (matches compressor output width)
- CW, 32, chunk width added per cycle; NCH = ceil(DW/CW) (4 at defaults; last chunk 10 bits)

- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- i_valid  input  1  carry-save pair valid
- i_ready  output  1  block can accept a pair
- i_c  input  DW  carry vector from compressor
- i_s  input  DW  sum vector from compressor
- i_flush  input  1  kill current operation, return to IDLE
- o_valid  output  1  result valid
- o_ready  input  1  consumer accepts result
- o_res  output  DW  (i_c + i_s) mod 2^DW
- o_cout  output  1  carry out of bit DW-1 (informational)

## Operation
- State machine: IDLE, ADD, DONE. Chunk index register idx (0..NCH-1). Chunk carry register cy.
- i_ready = (state == IDLE). o_valid = (state == DONE).
- IDLE: when i_valid & i_ready & ~i_flush, capture i_c/i_s into operand registers, set idx=0 and cy=0, and go to ADD.
- ADD: each cycle compute {cy_n, r} = c[idx] + s[idx] + cy, where c[k]/s[k] are bits [k*CW +: CW]. Write r into o_res chunk idx and set cy = cy_n.
  - If idx == NCH-1, use a width of DW-(NCH-1)*CW, write the carry out of that chunk to o_cout, and go to DONE.
  - Otherwise idx++.
- DONE: hold o_res/o_cout stable. When o_ready is high, go to IDLE. New input is accepted only from IDLE, i.e. the cycle after the DONE handshake.
- Flush: i_flush sends state to IDLE on the next edge from any state and has priority over every other transition.
  - An accept in the same cycle as i_flush is ignored. The upstream must treat it as dropped.
  - o_res/o_cout are not cleared by flush.
- Arithmetic: unsigned modulo 2^DW. Two's-complement products are correct mod 2^DW, because the compressor drops carries beyond DW. o_cout is not part of the product.
- o_res chunks update during ADD; contents are meaningful only while o_valid.
- Reset (asynchronous, any time, including mid-ADD):
  - state goes to IDLE, idx=0, cy=0, o_res=0, o_cout=0.
  - o_valid=0 and i_ready=1 while rst is high and after it is released.

## Timing
- Accept handshake at cycle 0 edge.
- ADD occupies cycles 1..NCH; the final chunk is registered at the end of cycle NCH.
- o_valid is high from cycle NCH+1 (cycle 5 at defaults).
- Minimum initiation interval is NCH+2 cycles: accept, NCH adds, one DONE cycle with o_ready=1. i_ready rises the cycle after the DONE handshake.
- o_valid has no combinational path from i_valid. i_ready has no combinational path from o_ready.
- o_res, o_cout and o_valid are registered and change only on clk edges or on rst assertion.

## Test plan
- Full carry ripple: i_c = 1, i_s = 2^106-1.
  - o_res = 0 and o_cout = 1.
  - o_valid rises exactly 5 cycles after the accept edge.
- Chunk-boundary carry: i_c = 0xFFFF_FFFF, i_s = 1.
  - o_res = 0x1_0000_0000 and o_cout = 0.
  - Also i_c = 2^96-1, i_s = 1 gives o_res = 2^96 (carry into the 10-bit last chunk).
- Backpressure: hold o_ready=0 for 3 cycles after o_valid.
  - o_res and o_valid stay stable and i_ready stays 0.
  - Raising o_ready gives i_ready = 1 on the next cycle, and a back-to-back second operand (i_c = 5, i_s = 7) yields o_res = 12.
- Flush: accept i_c = 3, i_s = 4, then pulse i_flush during the 2nd ADD cycle.
  - o_valid never asserts and i_ready = 1 on the following cycle.
  - The next operation (i_c = 10, i_s = 20) yields 30.
  - Flush asserted together with i_valid in IDLE: no operation starts.
- Reset mid-ADD: assert rst asynchronously during cycle 3.
  - Outputs immediately read o_res = 0, o_cout = 0, o_valid = 0, i_ready = 1.
  - After release, the next operation is correct.
- Random: 2000 random i_c/i_s pairs with random o_ready stalls.
  - Every o_res equals (i_c + i_s) mod 2^106 and o_cout matches bit 106.
  - Also run with CW = 106 (NCH = 1) and CW = 53.

Source files
------------

// File: rtl/e203_dsp_cpa_seq.sv
// Sequential carry-propagate adder: resolves a DSP carry-save pair into a binary sum,
// CW bits per cycle, with valid/ready on both sides and a flush that kills the operation.
module e203_dsp_cpa_seq #(
    parameter int unsigned DW = 106,
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_c,
    input  logic [DW-1:0] i_s,
    input  logic          i_flush,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_res,
    output logic          o_cout
);

    localparam int unsigned NCH = (DW + CW - 1) / CW;
    localparam int unsigned LW  = DW - (NCH - 1) * CW;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] c_q, c_d, s_q, s_d, res_q, res_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          cy_q, cy_d, cout_q, cout_d;

    logic [31:0]   shamt;
    logic [DW-1:0] cmask;
    logic [CW-1:0] c_ch, s_ch;
    logic [CW:0]   sum;

    always_comb begin
        shamt = 32'(idx_q) * CW;
        cmask = '0;
        cmask[CW-1:0] = '1;
        // Logical shift zero-fills, so the short last chunk sees zeros above LW.
        c_ch  = CW'(c_q >> shamt);
        s_ch  = CW'(s_q >> shamt);
        sum   = {1'b0, c_ch} + {1'b0, s_ch} + {{CW{1'b0}}, cy_q};
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        s_d     = s_q;
        res_d   = res_q;
        idx_d   = idx_q;
        cy_d    = cy_q;
        cout_d  = cout_q;
        unique case (state_q)
            StIdle: begin
                if (i_valid && !i_flush) begin
                    state_d = StAdd;
                    c_d     = i_c;
                    s_d     = i_s;
                    idx_d   = '0;
                    cy_d    = 1'b0;
                end
            end
            StAdd: begin
                // Bits shifted past DW-1 (last-chunk carry) are truncated away.
                res_d = (res_q & ~(cmask << shamt)) | (DW'(sum[CW-1:0]) << shamt);
                if (idx_q == IW'(NCH - 1)) begin
                    cout_d  = sum[LW];
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                    cy_d  = sum[CW];
                end
            end
            StDone: begin
                if (o_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (i_flush) state_d = StIdle;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            c_q     <= '0;
            s_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            cy_q    <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            s_q     <= s_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            cy_q    <= cy_d;
            cout_q  <= cout_d;
        end
    end

    assign i_ready = (state_q == StIdle);
    assign o_valid = (state_q == StDone);
    assign o_res   = res_q;
    assign o_cout  = cout_q;

endmodule

// File: tb/tb_e203_dsp_cpa_seq.sv
// Directed and random checks of the sequential carry-propagate adder at CW = 32, 106 and 53.
module tb_e203_dsp_cpa_seq;

    localparam int DW = 106;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_ready = 1'b0;
    logic [DW-1:0] i_c = '0;
    logic [DW-1:0] i_s = '0;

    logic          ir0, ov0, co0, ir1, ov1, co1, ir2, ov2, co2;
    logic [DW-1:0] res0, res1, res2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    e203_dsp_cpa_seq #(.DW(DW), .CW(32)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir0), .i_c(i_c), .i_s(i_s),
        .i_flush(i_flush), .o_valid(ov0), .o_ready(o_ready), .o_res(res0), .o_cout(co0)
    );
    e203_dsp_cpa_seq #(.DW(DW), .CW(106)) dut_w (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir1), .i_c(i_c), .i_s(i_s),
        .i_flush(i_flush), .o_valid(ov1), .o_ready(o_ready), .o_res(res1), .o_cout(co1)
    );
    e203_dsp_cpa_seq #(.DW(DW), .CW(53)) dut_h (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(ir2), .i_c(i_c), .i_s(i_s),
        .i_flush(i_flush), .o_valid(ov2), .o_ready(o_ready), .o_res(res2), .o_cout(co2)
    );

    // Presents a pair at a negedge; returns at the next negedge (cycle 1, first ADD cycle).
    task automatic start_op(input logic [DW-1:0] c, input logic [DW-1:0] s);
        @(negedge clk);
        i_c = c;
        i_s = s;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Counts cycles (starting at cycle 1) until the main DUT shows o_valid, bounded.
    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!ov0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hs: o_valid=%b i_ready=%b, need 0/1", ov0, ir0);
        end
        n_tests++;
        if (res0 !== '0 || co0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: o_res=%h o_cout=%b, need 0/0", res0, co0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ov0 !== 1'b0 || ir0 !== 1'b1 || res0 !== '0) begin
            n_fail++;
            $display("FAIL reset_release: o_valid=%b i_ready=%b o_res=%h, need 0/1/0",
                     ov0, ir0, res0);
        end
    endtask

    task automatic test_ripple();
        int cyc;
        start_op(106'd1, {DW{1'b1}});
        n_tests++;
        if (ir0 !== 1'b0) begin
            n_fail++;
            $display("FAIL ripple_busy: i_ready=%b, need 0", ir0);
        end
        wait_valid(cyc);
        n_tests++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL ripple_latency: o_valid at cycle %0d, need 5", cyc);
        end
        n_tests++;
        if (res0 !== '0 || co0 !== 1'b1) begin
            n_fail++;
            $display("FAIL ripple_value: o_res=%h o_cout=%b, need 0/1", res0, co0);
        end
        finish_op();
    endtask

    task automatic test_chunk_boundary();
        int cyc;
        logic [DW-1:0] c96;
        start_op(106'hFFFF_FFFF, 106'd1);
        wait_valid(cyc);
        n_tests++;
        if (cyc >= 50 || res0 !== 106'h1_0000_0000 || co0 !== 1'b0) begin
            n_fail++;
            $display("FAIL chunk32: o_res=%h o_cout=%b cyc=%0d, need 100000000/0", res0, co0, cyc);
        end
        finish_op();
        c96 = '0;
        c96[95:0] = '1;
        start_op(c96, 106'd1);
        wait_valid(cyc);
        n_tests++;
        if (cyc >= 50 || res0 !== (106'd1 << 96) || co0 !== 1'b0) begin
            n_fail++;
            $display("FAIL chunk96: o_res=%h o_cout=%b cyc=%0d, need 2^96/0", res0, co0, cyc);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        int cyc;
        start_op(106'd123, 106'd456);
        wait_valid(cyc);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (ov0 !== 1'b1 || res0 !== 106'd579 || ir0 !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: o_valid=%b o_res=%0d i_ready=%b, need 1/579/0",
                         k, ov0, res0, ir0);
            end
            @(negedge clk);
        end
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        n_tests++;
        if (ir0 !== 1'b1 || ov0 !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_release: i_ready=%b o_valid=%b, need 1/0", ir0, ov0);
        end
        i_c = 106'd5;
        i_s = 106'd7;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        wait_valid(cyc);
        n_tests++;
        if (cyc !== 5 || res0 !== 106'd12) begin
            n_fail++;
            $display("FAIL back_to_back: o_res=%0d cyc=%0d, need 12 at 5", res0, cyc);
        end
        finish_op();
    endtask

    task automatic test_flush();
        int cyc;
        bit seen;
        start_op(106'd3, 106'd4);
        @(negedge clk);
        i_flush = 1'b1;
        @(negedge clk);
        i_flush = 1'b0;
        n_tests++;
        if (ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: i_ready=%b, need 1", ir0);
        end
        seen = 1'b0;
        repeat (8) begin
            if (ov0) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_novalid: o_valid seen=1, need 0");
        end
        start_op(106'd10, 106'd20);
        wait_valid(cyc);
        n_tests++;
        if (cyc !== 5 || res0 !== 106'd30) begin
            n_fail++;
            $display("FAIL flush_next: o_res=%0d cyc=%0d, need 30 at 5", res0, cyc);
        end
        finish_op();
        @(negedge clk);
        i_c = 106'd1;
        i_s = 106'd1;
        i_valid = 1'b1;
        i_flush = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            if (ov0 || !ir0) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_accept: operation started=1, need 0");
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op({DW{1'b1}}, {DW{1'b1}});
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (res0 !== '0 || co0 !== 1'b0 || ov0 !== 1'b0 || ir0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: o_res=%h o_cout=%b o_valid=%b i_ready=%b, need 0/0/0/1",
                     res0, co0, ov0, ir0);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op(106'h3_0000_0000_0000_0000_0000_0001, 106'hFFFF_FFFF_FFFF);
        wait_valid(cyc);
        n_tests++;
        if (cyc !== 5 || res0 !== 106'h3_0000_0000_0001_0000_0000_0000 || co0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_next: o_res=%h o_cout=%b cyc=%0d", res0, co0, cyc);
        end
        finish_op();
    endtask

    task automatic test_random();
        logic [127:0]  tmp;
        logic [DW-1:0] c, s;
        logic [DW:0]   expv;
        int cyc;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            tmp = {$urandom(), $urandom(), $urandom(), $urandom()};
            c = tmp[DW-1:0];
            tmp = {$urandom(), $urandom(), $urandom(), $urandom()};
            s = tmp[DW-1:0];
            if ($urandom_range(0, 7) == 0) c = {DW{1'b1}};
            if ($urandom_range(0, 7) == 0) s = {DW{1'b1}} ^ (c & {DW{tmp[127]}});
            expv = {1'b0, c} + {1'b0, s};
            start_op(c, s);
            cyc = 1;
            while (!(ov0 && ov1 && ov2) && cyc < 50) begin
                @(negedge clk);
                cyc++;
            end
            n_tests++;
            if (cyc >= 50) begin
                n_fail++;
                $display("FAIL rand_timeout[%0d]: o_valid=%b%b%b, need 111", n, ov0, ov1, ov2);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_tests++;
            if (res0 !== expv[DW-1:0] || co0 !== expv[DW]) begin
                n_fail++;
                $display("FAIL rand_cw32[%0d]: got %b_%h, need %b_%h", n, co0, res0,
                         expv[DW], expv[DW-1:0]);
            end
            n_tests++;
            if (res1 !== expv[DW-1:0] || co1 !== expv[DW]) begin
                n_fail++;
                $display("FAIL rand_cw106[%0d]: got %b_%h, need %b_%h", n, co1, res1,
                         expv[DW], expv[DW-1:0]);
            end
            n_tests++;
            if (res2 !== expv[DW-1:0] || co2 !== expv[DW]) begin
                n_fail++;
                $display("FAIL rand_cw53[%0d]: got %b_%h, need %b_%h", n, co2, res2,
                         expv[DW], expv[DW-1:0]);
            end
            finish_op();
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_chunk_boundary();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
